// File: rtl/mult_rf_engine_if.sv
// rtl/mult_rf_engine_if.sv - handshake and bus bundle for the sequential multiplier engine
//
// Purpose: groups the command, register-file write, RAM read and status
// signals of mult_rf_engine so the engine and its driver share one bundle.
// Ports (all carried as interface signals):
//   start, signed_mode, adr1_r, adr2_r, adr_ram  - multiply command
//   rf_we, rf_wadr, rf_wdata                     - register-file write port
//   ram_rd_adr / ram_rd_data                     - result-RAM read port
//   result, busy, done, st_out                   - status back to the driver
// Modports: master drives commands, slave is the engine.
interface mult_rf_engine_if #(
  parameter int W         = 4,
  parameter int RF_DEPTH  = 8,
  parameter int RAM_DEPTH = 16
);
  localparam int RA = $clog2(RF_DEPTH);
  localparam int MA = $clog2(RAM_DEPTH);

  logic            start;
  logic            signed_mode;
  logic [RA-1:0]   adr1_r;
  logic [RA-1:0]   adr2_r;
  logic [MA-1:0]   adr_ram;
  logic            rf_we;
  logic [RA-1:0]   rf_wadr;
  logic [W-1:0]    rf_wdata;
  logic [MA-1:0]   ram_rd_adr;
  logic [2*W-1:0]  ram_rd_data;
  logic [2*W-1:0]  result;
  logic            busy;
  logic            done;
  logic [3:0]      st_out;

  modport master (
    output start, signed_mode, adr1_r, adr2_r, adr_ram,
    output rf_we, rf_wadr, rf_wdata, ram_rd_adr,
    input  ram_rd_data, result, busy, done, st_out
  );

  modport slave (
    input  start, signed_mode, adr1_r, adr2_r, adr_ram,
    input  rf_we, rf_wadr, rf_wdata, ram_rd_adr,
    output ram_rd_data, result, busy, done, st_out
  );
endinterface

// File: rtl/mult_rf_engine.sv
// rtl/mult_rf_engine.sv - shift-add multiplier with operand register file and result RAM
//
// Purpose: on start, fetches two W-bit operands from the register file,
// multiplies them one bit per cycle (unsigned or two's-complement), writes
// the 2W-bit product to the result RAM and pulses done.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mult_rf_engine_if.slave (command, RF write, RAM read, status)
module mult_rf_engine #(
  parameter int W         = 4,
  parameter int RF_DEPTH  = 8,
  parameter int RAM_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  mult_rf_engine_if.slave    bus
);
  localparam int RA = $clog2(RF_DEPTH);
  localparam int MA = $clog2(RAM_DEPTH);
  localparam int PW = 2 * W;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    FETCH = 4'd1,
    MULT  = 4'd2,
    FIX   = 4'd3,
    STORE = 4'd4,
    DONE  = 4'd5
  } state_t;

  state_t          state;
  logic [RA-1:0]   adr1_q;
  logic [RA-1:0]   adr2_q;
  logic [MA-1:0]   adr_ram_q;
  logic            sgn_q;
  logic            neg;
  logic [PW-1:0]   mcand;
  logic [W-1:0]    mplier;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   result_q;
  logic [PW-1:0]   rd_q;
  logic            busy_q;
  logic            done_q;

  logic [W-1:0]    rf  [RF_DEPTH];
  logic [PW-1:0]   ram [RAM_DEPTH];

  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic            ram_we;

  // Combinational RF read: a write landing on the FETCH edge is not yet
  // visible, so FETCH naturally uses the old operand.
  assign op_a = rf[adr1_q];
  assign op_b = rf[adr2_q];

  // |-2^(W-1)| wraps back to 2^(W-1), which is correct when read unsigned.
  assign mag_a = (sgn_q && op_a[W-1]) ? (~op_a + W'(1)) : op_a;
  assign mag_b = (sgn_q && op_b[W-1]) ? (~op_b + W'(1)) : op_b;

  // Gated by rst so a reset on the STORE edge leaves the RAM untouched.
  assign ram_we = (state == STORE) && !rst;

  always_ff @(posedge clk) begin
    if (bus.rf_we) rf[bus.rf_wadr] <= bus.rf_wdata;
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[adr_ram_q] <= acc;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_q <= '0;
    else     rd_q <= ram[bus.ram_rd_adr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      adr1_q    <= '0;
      adr2_q    <= '0;
      adr_ram_q <= '0;
      sgn_q     <= 1'b0;
      neg       <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            adr1_q    <= bus.adr1_r;
            adr2_q    <= bus.adr2_r;
            adr_ram_q <= bus.adr_ram;
            sgn_q     <= bus.signed_mode;
            busy_q    <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          mcand  <= {{W{1'b0}}, mag_a};
          mplier <= mag_b;
          neg    <= sgn_q & (op_a[W-1] ^ op_b[W-1]);
          acc    <= '0;
          cnt    <= '0;
          state  <= MULT;
        end
        MULT: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          if (neg) acc <= ~acc + PW'(1);
          state <= STORE;
        end
        STORE: begin
          result_q <= acc;
          done_q   <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_rd_data = rd_q;
  assign bus.result      = result_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.st_out      = state;
endmodule
